// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with WB->ID bypass, load-use bubble insertion,
// branch flush and a saturating count of load-use stall cycles.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [7:0]        id_ctrl,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [DATA_W-1:0] rf_data_a,
  input  logic [DATA_W-1:0] rf_data_b,
  input  logic              wb_reg_write,
  input  logic [4:0]        wb_write_reg,
  input  logic [DATA_W-1:0] wb_write_data,
  output logic              hazard_stall,
  output logic              ex_valid,
  output logic [7:0]        ex_ctrl,
  output logic [DATA_W-1:0] ex_data_a,
  output logic [DATA_W-1:0] ex_data_b,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic [CNT_W-1:0]  stall_count
);

  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;

  // The register file's read path does not see its own falling-edge write,
  // so a same-cycle WB result is forwarded here; $0 always reads as zero.
  always_comb begin
    if (id_rs == 5'd0)
      op_a = '0;
    else if (wb_reg_write && (wb_write_reg == id_rs))
      op_a = wb_write_data;
    else
      op_a = rf_data_a;
  end

  always_comb begin
    if (id_rt == 5'd0)
      op_b = '0;
    else if (wb_reg_write && (wb_write_reg == id_rt))
      op_b = wb_write_data;
    else
      op_b = rf_data_b;
  end

  // ex_ctrl[6] is mem_read: a load in EX whose target is read by ID.
  assign hazard_stall = id_valid & ex_valid & ex_ctrl[6] & (ex_rt != 5'd0) &
                        ((ex_rt == id_rs) | (ex_rt == id_rt)) & ~flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid    <= 1'b0;
      ex_ctrl     <= '0;
      ex_data_a   <= '0;
      ex_data_b   <= '0;
      ex_imm      <= '0;
      ex_pc4      <= '0;
      ex_rs       <= '0;
      ex_rt       <= '0;
      ex_rd       <= '0;
      stall_count <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= '0;
    end else if (hazard_stall) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= '0;
      if (stall_count != {CNT_W{1'b1}})
        stall_count <= stall_count + CNT_W'(1);
    end else begin
      ex_valid  <= id_valid;
      ex_ctrl   <= id_valid ? id_ctrl : 8'h00;
      ex_data_a <= op_a;
      ex_data_b <= op_b;
      ex_imm    <= id_imm;
      ex_pc4    <= id_pc4;
      ex_rs     <= id_rs;
      ex_rt     <= id_rt;
      ex_rd     <= id_rd;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: table of per-cycle vectors plus a random capture run,
// expected EX state queued at drive time and compared after the clock edge.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, flush, id_valid, wb_reg_write;
  logic [7:0]  id_ctrl;
  logic [4:0]  id_rs, id_rt, id_rd, wb_write_reg;
  logic [31:0] id_imm, id_pc4, rf_data_a, rf_data_b, wb_write_data;

  logic        hazard_stall, ex_valid;
  logic [7:0]  ex_ctrl;
  logic [31:0] ex_data_a, ex_data_b, ex_imm, ex_pc4;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [15:0] stall_count;

  logic        s_hazard_stall, s_ex_valid;
  logic [7:0]  s_ex_ctrl;
  logic [31:0] s_ex_data_a, s_ex_data_b, s_ex_imm, s_ex_pc4;
  logic [4:0]  s_ex_rs, s_ex_rt, s_ex_rd;
  logic [1:0]  s_stall_count;

  id_ex_stage #(.DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .flush(flush), .id_valid(id_valid),
    .id_ctrl(id_ctrl), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_imm(id_imm), .id_pc4(id_pc4), .rf_data_a(rf_data_a), .rf_data_b(rf_data_b),
    .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data),
    .hazard_stall(hazard_stall), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl),
    .ex_data_a(ex_data_a), .ex_data_b(ex_data_b), .ex_imm(ex_imm), .ex_pc4(ex_pc4),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .stall_count(stall_count)
  );

  id_ex_stage #(.DATA_W(32), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .flush(flush), .id_valid(id_valid),
    .id_ctrl(id_ctrl), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_imm(id_imm), .id_pc4(id_pc4), .rf_data_a(rf_data_a), .rf_data_b(rf_data_b),
    .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data),
    .hazard_stall(s_hazard_stall), .ex_valid(s_ex_valid), .ex_ctrl(s_ex_ctrl),
    .ex_data_a(s_ex_data_a), .ex_data_b(s_ex_data_b), .ex_imm(s_ex_imm), .ex_pc4(s_ex_pc4),
    .ex_rs(s_ex_rs), .ex_rt(s_ex_rt), .ex_rd(s_ex_rd), .stall_count(s_stall_count)
  );

  typedef struct {
    logic        rst, fl, idv;
    logic [7:0]  ctrl;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm, ra, rb;
    logic        wbw;
    logic [4:0]  wbr;
    logic [31:0] wbd;
    logic        chk_haz, exp_haz, exp_v;
    logic [7:0]  exp_ctrl;
    logic [31:0] exp_a, exp_b;
    logic        cap;
    logic [15:0] exp_cnt;
    logic [1:0]  exp_sat;
  } vec_t;

  typedef struct {
    logic        v;
    logic [7:0]  ctrl;
    logic [31:0] a, b, imm, pc4;
    logic [4:0]  rs, rt, rd;
    logic [15:0] cnt;
    logic [1:0]  sat;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  // EX fields that only change on a capture edge; tracked from driven stimulus
  logic [31:0] last_imm = '0, last_pc4 = '0;
  logic [4:0]  last_rs = '0, last_rt = '0, last_rd = '0;

  function automatic vec_t mk(
      input logic rst, input logic fl, input logic idv, input logic [7:0] ctrl,
      input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
      input logic [31:0] imm, input logic [31:0] ra, input logic [31:0] rb,
      input logic wbw, input logic [4:0] wbr, input logic [31:0] wbd,
      input logic chk_haz, input logic exp_haz,
      input logic exp_v, input logic [7:0] exp_ctrl,
      input logic [31:0] exp_a, input logic [31:0] exp_b,
      input logic cap, input logic [15:0] exp_cnt, input logic [1:0] exp_sat);
    vec_t v;
    v.rst = rst; v.fl = fl; v.idv = idv; v.ctrl = ctrl;
    v.rs = rs; v.rt = rt; v.rd = rd; v.imm = imm; v.ra = ra; v.rb = rb;
    v.wbw = wbw; v.wbr = wbr; v.wbd = wbd;
    v.chk_haz = chk_haz; v.exp_haz = exp_haz; v.exp_v = exp_v; v.exp_ctrl = exp_ctrl;
    v.exp_a = exp_a; v.exp_b = exp_b; v.cap = cap; v.exp_cnt = exp_cnt; v.exp_sat = exp_sat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    reset = v.rst; flush = v.fl; id_valid = v.idv; id_ctrl = v.ctrl;
    id_rs = v.rs; id_rt = v.rt; id_rd = v.rd; id_imm = v.imm;
    id_pc4 = 32'h400 + 32'(4 * idx);
    rf_data_a = v.ra; rf_data_b = v.rb;
    wb_reg_write = v.wbw; wb_write_reg = v.wbr; wb_write_data = v.wbd;
    if (v.rst) begin
      last_imm = '0; last_pc4 = '0; last_rs = '0; last_rt = '0; last_rd = '0;
    end else if (v.cap) begin
      last_imm = v.imm; last_pc4 = id_pc4; last_rs = v.rs; last_rt = v.rt; last_rd = v.rd;
    end
    e.v = v.exp_v; e.ctrl = v.exp_ctrl; e.a = v.exp_a; e.b = v.exp_b;
    e.imm = last_imm; e.pc4 = last_pc4; e.rs = last_rs; e.rt = last_rt; e.rd = last_rd;
    e.cnt = v.exp_cnt; e.sat = v.exp_sat;
    sb.push_back(e);
    #1;
    if (v.chk_haz) chk($sformatf("hazard_stall[%0d]", idx), 32'(hazard_stall), 32'(v.exp_haz));
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk($sformatf("ex_valid[%0d]", idx), 32'(ex_valid), 32'(e.v));
    chk($sformatf("ex_ctrl[%0d]", idx), 32'(ex_ctrl), 32'(e.ctrl));
    chk($sformatf("ex_data_a[%0d]", idx), ex_data_a, e.a);
    chk($sformatf("ex_data_b[%0d]", idx), ex_data_b, e.b);
    chk($sformatf("ex_imm[%0d]", idx), ex_imm, e.imm);
    chk($sformatf("ex_pc4[%0d]", idx), ex_pc4, e.pc4);
    chk($sformatf("ex_rs[%0d]", idx), 32'(ex_rs), 32'(e.rs));
    chk($sformatf("ex_rt[%0d]", idx), 32'(ex_rt), 32'(e.rt));
    chk($sformatf("ex_rd[%0d]", idx), 32'(ex_rd), 32'(e.rd));
    chk($sformatf("stall_count[%0d]", idx), 32'(stall_count), 32'(e.cnt));
    chk($sformatf("sat_stall_count[%0d]", idx), 32'(s_stall_count), 32'(e.sat));
    @(negedge clk);
  endtask

  function automatic logic [1:0] sat3(input int n);
    return (n > 3) ? 2'd3 : 2'(n);
  endfunction

  initial begin
    vec_t rv;
    int base;
    // reset, twice, with junk on the inputs
    vecs.push_back(mk(1,0,1,8'hFF,3,4,5,32'hDEAD,32'hAA,32'hBB,1,3,32'hCC, 0,0, 0,8'h00,0,0, 0,0,0));
    vecs.push_back(mk(1,0,1,8'hD0,9,9,9,32'hBEEF,32'hAA,32'hBB,1,9,32'hCC, 1,0, 0,8'h00,0,0, 0,0,0));
    // normal capture, rs bypass, $0 never bypassed, rt bypass
    vecs.push_back(mk(0,0,1,8'h83,8,9,10,32'hFFFFFFFC,1,2,0,0,0, 1,0, 1,8'h83,1,2, 1,0,0));
    vecs.push_back(mk(0,0,1,8'h83,8,9,11,32'h4,1,2,1,8,32'h1234, 1,0, 1,8'h83,32'h1234,2, 1,0,0));
    vecs.push_back(mk(0,0,1,8'h83,0,9,12,32'h5,32'h55,7,1,0,32'h9999, 1,0, 1,8'h83,0,7, 1,0,0));
    vecs.push_back(mk(0,0,1,8'h83,5,6,13,32'h6,32'h11,32'h22,1,6,32'hABCD, 1,0, 1,8'h83,32'h11,32'hABCD, 1,0,0));
    // lw r9 then a use of r9 via rs: one bubble, then the held instruction
    vecs.push_back(mk(0,0,1,8'hD0,1,9,14,32'h8,32'h100,32'h200,0,0,0, 1,0, 1,8'hD0,32'h100,32'h200, 1,0,0));
    vecs.push_back(mk(0,0,1,8'h83,9,2,15,32'hC,32'h31,32'h32,0,0,0, 1,1, 0,8'h00,32'h100,32'h200, 0,1,1));
    vecs.push_back(mk(0,0,1,8'h83,9,2,15,32'hC,32'h31,32'h32,0,0,0, 1,0, 1,8'h83,32'h31,32'h32, 1,1,1));
    // same pair under flush: flush wins, counter untouched
    vecs.push_back(mk(0,0,1,8'hD0,1,9,14,32'h8,32'h100,32'h200,0,0,0, 1,0, 1,8'hD0,32'h100,32'h200, 1,1,1));
    vecs.push_back(mk(0,1,1,8'h83,9,2,15,32'hC,32'h31,32'h32,0,0,0, 1,0, 0,8'h00,32'h100,32'h200, 0,1,1));
    // invalid ID: data captured, control zeroed
    vecs.push_back(mk(0,0,0,8'hFF,3,4,16,32'h10,32'h77,32'h88,0,0,0, 1,0, 0,8'h00,32'h77,32'h88, 1,1,1));
    // load to $0 never stalls
    vecs.push_back(mk(0,0,1,8'hD0,1,0,17,32'h14,32'h5,32'h66,0,0,0, 1,0, 1,8'hD0,32'h5,0, 1,1,1));
    vecs.push_back(mk(0,0,1,8'h83,0,0,18,32'h18,1,2,0,0,0, 1,0, 1,8'h83,0,0, 1,1,1));
    // load-use through rt
    vecs.push_back(mk(0,0,1,8'hD0,2,7,19,32'h1C,3,4,0,0,0, 1,0, 1,8'hD0,3,4, 1,1,1));
    vecs.push_back(mk(0,0,1,8'h83,4,7,20,32'h20,8,9,0,0,0, 1,1, 0,8'h00,3,4, 0,2,2));
    vecs.push_back(mk(0,0,1,8'h83,4,7,20,32'h20,8,9,0,0,0, 1,0, 1,8'h83,8,9, 1,2,2));
    // reset in the middle of a bubble drops the pending instruction
    vecs.push_back(mk(0,0,1,8'hD0,1,9,21,32'h24,32'h41,32'h42,0,0,0, 1,0, 1,8'hD0,32'h41,32'h42, 1,2,2));
    vecs.push_back(mk(1,0,1,8'h83,9,3,22,32'h28,32'h43,32'h44,0,0,0, 1,1, 0,8'h00,0,0, 0,0,0));
    vecs.push_back(mk(0,0,0,8'h00,0,0,0,0,0,0,0,0,0, 1,0, 0,8'h00,0,0, 1,0,0));
    // five load-use pairs: 2-bit counter reads 1,2,3,3,3
    for (int k = 0; k < 5; k++) begin
      base = 32'h50 + k;
      vecs.push_back(mk(0,0,1,8'hD0,1,9,23,32'(k),32'(base),32'(base+16),0,0,0,
                        1,0, 1,8'hD0,32'(base),32'(base+16), 1,16'(k),sat3(k)));
      vecs.push_back(mk(0,0,1,8'h83,3,9,24,32'(k+100),32'h70,32'h80,0,0,0,
                        1,1, 0,8'h00,32'(base),32'(base+16), 0,16'(k+1),sat3(k+1)));
      vecs.push_back(mk(0,0,1,8'h83,3,9,24,32'(k+100),32'h70,32'h80,0,0,0,
                        1,0, 1,8'h83,32'h70,32'h80, 1,16'(k+1),sat3(k+1)));
    end

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // random non-load captures with occasional same-register WB bypass
    for (int i = 0; i < 8; i++) begin
      rv = mk(0,0,1,8'($urandom) & 8'hBF,5'($urandom),5'($urandom),5'($urandom),
              $urandom,$urandom,$urandom,1'($urandom),5'($urandom),$urandom,
              1,0, 1,8'h00,0,0, 1,5,3);
      if (i[0]) rv.wbr = rv.rs; else rv.wbr = rv.rt;
      rv.exp_ctrl = rv.ctrl;
      rv.exp_a = (rv.rs == 5'd0) ? 32'h0 : (rv.wbw && rv.wbr == rv.rs) ? rv.wbd : rv.ra;
      rv.exp_b = (rv.rt == 5'd0) ? 32'h0 : (rv.wbw && rv.wbr == rv.rt) ? rv.wbd : rv.rb;
      apply(rv, 100 + i);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the pipelined MIPS datapath. It sits directly downstream of the register file. It captures the two read operands, the decoded control and the instruction fields on each rising clock edge and presents them to the execute stage. It also provides:
- the WB→ID same-cycle bypass (the register file writes on the falling edge and its read path does not track writes);
- load-use hazard detection, with bubble insertion;
- branch flush;
- a saturating stall counter.

## Interface
Parameters:
- DATA_W, 32, datapath width
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- flush  in  1  branch taken / squash; the ID instruction must not enter EX
- id_valid  in  1  ID holds a real instruction
- id_ctrl  in  8  {reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst, alu_op[1:0]}, MSB first
- id_rs, id_rt, id_rd  in  5 each  register specifiers
- id_imm  in  DATA_W  sign-extended immediate
- id_pc4  in  DATA_W  PC+4
- rf_data_a, rf_data_b  in  DATA_W  register file outputs for id_rs and id_rt
- wb_reg_write  in  1  WB stage writes the register file this cycle
- wb_write_reg  in  5  WB destination register
- wb_write_data  in  DATA_W  WB write data
- hazard_stall  out  1  combinational; holds PC and IF/ID when 1
- ex_valid  out  1  EX holds a real instruction
- ex_ctrl  out  8  latched control
- ex_data_a, ex_data_b  out  DATA_W  latched operands after bypass
- ex_imm, ex_pc4  out  DATA_W  latched immediate and PC+4
- ex_rs, ex_rt, ex_rd  out  5 each  latched specifiers
- stall_count  out  CNT_W  load-use stall cycles since reset

## Operation
Operand selection (combinational, per operand; shown for A, B uses id_rt / rf_data_b):
- If id_rs == 0: A = 0.
- Else if wb_reg_write and wb_write_reg == id_rs: A = wb_write_data.
- Else: A = rf_data_a.

Load-use hazard:
- hazard_stall = id_valid & ex_valid & ex_ctrl[6] (mem_read) & (ex_rt != 0) & (ex_rt == id_rs | ex_rt == id_rt) & !flush.
- Detection is purely combinational; no registered input feeds it other than the EX outputs of this block.

Register update, rising edge, in priority order:
1. reset: every output register is cleared to 0, including stall_count.
2. flush: ex_valid ← 0 and ex_ctrl ← 0. All other EX fields hold their values.
3. hazard_stall: bubble. ex_valid ← 0 and ex_ctrl ← 0; all other EX fields hold. stall_count increments.
4. Otherwise, capture:
   - ex_valid ← id_valid;
   - ex_ctrl ← id_valid ? id_ctrl : 0;
   - all other fields ← ID values, with operands A and B taken after bypass.

stall_count saturates at all ones; it does not wrap.

When id_valid = 0, the captured EX instruction is invalid with zero control. The data fields are still captured.

## Timing
- Latency: 1 cycle from ID inputs to EX outputs.
- hazard_stall has 0-cycle latency from ID inputs and EX state.
- Reset values: every registered output is 0. hazard_stall is 0 while ex_valid = 0.
- A load-use pair yields exactly one bubble cycle. On the next edge ex_valid = 0, so hazard_stall deasserts and the held ID instruction is captured.
- Simultaneous flush and hazard: flush wins. hazard_stall stays 0 and stall_count does not increment.
- A WB write to the register being read in the same cycle is always bypassed. A WB write to $0 is never bypassed.
- If reset is asserted mid-bubble, the next edge clears all state, and the pending ID instruction is not retained.

## Test plan
- Reset: hold reset for 2 cycles with arbitrary inputs → all ex_* = 0, stall_count = 0, hazard_stall = 0.
- Normal capture:
  - Stimulus: id_valid=1, id_ctrl=0x83, id_rs=8, id_rt=9, rf_data_a=1, rf_data_b=2, id_imm=0xFFFFFFFC.
  - Required, next cycle: ex_valid=1, ex_ctrl=0x83, ex_data_a=1, ex_data_b=2, ex_imm=0xFFFFFFFC.
- WB bypass and $0:
  - Stimulus: wb_reg_write=1, wb_write_reg=8, wb_write_data=0x1234, id_rs=8, rf_data_a=1.
  - Required: ex_data_a=0x1234.
  - Then: id_rs=0 with rf_data_a=0x55 and WB writing reg 0 → ex_data_a=0.
- Load-use:
  - Stimulus: EX holds lw (ex_ctrl=0xD0, ex_rt=9); ID holds an instruction with id_rs=9.
  - Required: hazard_stall=1 in that cycle; next cycle ex_valid=0, ex_ctrl=0, stall_count=1, hazard_stall=0; the following cycle the ID instruction is captured.
- Flush versus hazard: apply the same load-use setup with flush=1 → hazard_stall=0, next ex_valid=0, stall_count unchanged.
- Saturation: use CNT_W=2 and force 5 consecutive load-use pairs → stall_count reads 1, 2, 3, 3, 3.
